// File: rtl/apb_req_arbiter_if.sv
// apb_req_arbiter_if: APB3 bus between the request arbiter (master) and the interconnect (slave)
interface apb_req_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;
    modport master (output paddr, psel, penable, pwrite, pwdata, input pready, prdata);
    modport slave (input paddr, psel, penable, pwrite, pwdata, output pready, prdata);
endinterface

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin arbiter sequencing requester transfers onto an APB3 master port
module apb_req_arbiter #(
    parameter int NREQ       = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input  logic                       PCLK,
    input  logic                       PRESETn,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0]            req_write,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]            req_done,
    output logic [DATA_WIDTH-1:0]      rsp_rdata,
    output logic                       rsp_err,
    output logic                       busy,
    apb_req_arbiter_if.master          apb
);
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CLAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t          state, nxt;
    logic [IW-1:0]   last, win;
    logic [CW-1:0]   cnt;
    logic [NREQ-1:0] elig, last_oh, done_n;
    logic            fin, any, take, psel_n, penable_n;

    function automatic logic [IW-1:0] rr(input logic [IW-1:0] base, input int k);
        int s = int'(base) + k;
        return IW'(s >= NREQ ? s - NREQ : s);
    endfunction

    always_ff @(posedge PCLK or negedge PRESETn)
        if (!PRESETn) state <= IDLE;
        else state <= nxt;

    // a requester whose done is pending or pulsing still holds valid, so it sits out
    always_comb begin
        last_oh = NREQ'(1) << last;
        fin = state == ACCESS && (apb.pready || (TIMEOUT != 0 && cnt == CLAST));
        elig = req_valid & ~req_done & (state == ACCESS ? ~last_oh : '1);
        any = |elig;
        win = last;
        for (int k = NREQ; k >= 1; k--)
            if (elig[rr(last, k)]) win = rr(last, k);
        take = (state == IDLE || fin) && any;
        nxt = state == SETUP ? ACCESS : (state == ACCESS && !fin) ? ACCESS : take ? SETUP : IDLE;
    end

    always_comb begin
        psel_n = nxt != IDLE;
        penable_n = nxt == ACCESS;
        done_n = fin ? last_oh : '0;
    end

    always_ff @(posedge PCLK or negedge PRESETn)
        if (!PRESETn) begin
            last <= IW'(NREQ - 1);
            cnt <= '0;
            req_done <= '0;
            rsp_rdata <= '0;
            rsp_err <= 1'b0;
            busy <= 1'b0;
            apb.psel <= 1'b0;
            apb.penable <= 1'b0;
            apb.pwrite <= 1'b0;
            apb.paddr <= '0;
            apb.pwdata <= '0;
        end else begin
            apb.psel <= psel_n;
            apb.penable <= penable_n;
            busy <= psel_n;
            req_done <= done_n;
            if (fin) begin
                rsp_rdata <= apb.pready && !apb.pwrite ? apb.prdata : '0;
                rsp_err <= !apb.pready;
            end
            if (take) begin
                last <= win;
                cnt <= '0;
                apb.pwrite <= req_write[win];
                apb.paddr <= req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                apb.pwdata <= req_wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
            end else if (state == ACCESS) begin
                cnt <= cnt + 1'b1;
            end
        end
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed tests with a transfer-level reference model checked every cycle
module tb_apb_req_arbiter;
    localparam int NREQ = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } txn_t;

    logic PCLK = 0;
    logic PRESETn = 0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_write = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_wdata = '0;
    logic [NREQ-1:0]    req_done;
    logic [DW-1:0]      rsp_rdata;
    logic               rsp_err;
    logic               busy;
    int total = 0;
    int bad = 0;

    apb_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_req_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK),
        .PRESETn(PRESETn),
        .req_valid(req_valid),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_done(req_done),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .busy(busy),
        .apb(bus)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // requesters: each presents its queue head and retires it the cycle after its done pulse
    txn_t q[NREQ][$];
    logic [NREQ-1:0] prev_done = '0;
    initial forever begin
        @(negedge PCLK);
        for (int i = 0; i < NREQ; i++) begin
            if (prev_done[i] && q[i].size() > 0) void'(q[i].pop_front());
            req_valid[i] = q[i].size() != 0;
            if (q[i].size() != 0) begin
                req_write[i] = q[i][0].w;
                req_addr[i*AW +: AW] = q[i][0].a;
                req_wdata[i*DW +: DW] = q[i][0].d;
            end
        end
        prev_done = PRESETn ? req_done : '0;
    end

    // reference model: a transfer is granted, spends one setup cycle, then completes on
    // the first ready access cycle or after TO unready ones; grants rotate past the last winner
    bit              m_active = 0;
    int              m_age = 0;
    int              m_cur = 0;
    int              m_last = NREQ - 1;
    int              m_w;
    bit              m_fin;
    logic [NREQ-1:0] m_done = '0;
    logic [NREQ-1:0] m_excl;
    logic            m_write = 0;
    logic [31:0]     m_addr = '0;
    logic [31:0]     m_wdata = '0;
    logic [31:0]     m_rdata = '0;
    logic            m_err = 0;
    initial forever begin
        @(posedge PCLK or negedge PRESETn);
        if (!PRESETn) begin
            m_active = 0; m_age = 0; m_cur = 0; m_last = NREQ - 1; m_done = '0;
            m_write = 0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_err = 0;
        end else begin
            m_fin = m_active && m_age >= 1 && (bus.pready || m_age == TO);
            m_excl = m_done;
            m_done = '0;
            if (m_fin) begin
                m_excl[m_cur] = 1'b1;
                m_done[m_cur] = 1'b1;
                m_rdata = (bus.pready && !m_write) ? bus.prdata : '0;
                m_err = !bus.pready;
            end
            if (!m_active || m_fin) begin
                m_w = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    if (m_w < 0 && req_valid[(m_last + k) % NREQ] && !m_excl[(m_last + k) % NREQ])
                        m_w = (m_last + k) % NREQ;
                end
                m_active = m_w >= 0;
                if (m_w >= 0) begin
                    m_cur = m_w; m_last = m_w; m_age = 0;
                    m_write = req_write[m_w];
                    m_addr = req_addr[m_w*AW +: AW];
                    m_wdata = req_wdata[m_w*DW +: DW];
                end
            end else begin
                m_age++;
            end
        end
    end

    initial forever begin
        @(negedge PCLK);
        if (PRESETn) begin
            check("psel", bus.psel, m_active);
            check("penable", bus.penable, m_active && m_age >= 1);
            check("busy", busy, m_active);
            check("pwrite", bus.pwrite, m_write);
            check("paddr", bus.paddr, m_addr);
            check("pwdata", bus.pwdata, m_wdata);
            check("req_done", req_done, m_done);
            if (m_done != 0) begin
                check("rsp_rdata", rsp_rdata, m_rdata);
                check("rsp_err", rsp_err, m_err);
            end
        end
    end

    task automatic push(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
        @(posedge PCLK);
        #1 q[i].push_back(txn_t'{w, a, d});
    endtask

    task automatic run(input int i, input int rdy_at, input int maxc,
                       output int n_psel, output int n_done, output int psel_cyc);
        n_psel = 0; n_done = 0; psel_cyc = 0;
        for (int n = 1; n <= maxc && n_done == 0; n++) begin
            @(negedge PCLK);
            if (n == rdy_at) bus.pready = 1;
            if (bus.psel && n_psel == 0) n_psel = n;
            if (bus.psel) psel_cyc++;
            if (req_done[i]) n_done = n;
        end
        if (n_done == 0) begin
            total++; bad++;
            $display("FAIL done_wait r%0d saw no done within %0d cycles", i, maxc);
        end
    endtask

    task automatic idle(output int extra);
        extra = 0;
        repeat (4) begin
            @(negedge PCLK);
            if (req_done != 0) extra++;
        end
    endtask

    task automatic collect(input int want, input int maxc, output int ord[$], output int at[$], output int drops);
        bit seen = 0;
        drops = 0;
        for (int n = 1; n <= maxc && ord.size() < want; n++) begin
            @(negedge PCLK);
            if (req_done != 0) begin
                ord.push_back(req_done[1] ? 1 : 0);
                at.push_back(n);
            end
            if (bus.psel) seen = 1;
            else if (seen && ord.size() < want) drops++;
        end
    endtask

    initial begin
        int np, nd, pc, ex, drops, w;
        int ord[$], at[$];
        int exp_ord[4] = '{0, 1, 0, 1};
        bus.pready = 1;
        bus.prdata = '0;
        repeat (2) @(negedge PCLK);
        check("rst_psel", bus.psel, 0);
        check("rst_penable", bus.penable, 0);
        check("rst_busy", busy, 0);
        check("rst_done", req_done, 0);
        check("rst_paddr", bus.paddr, 0);
        check("rst_pwdata", bus.pwdata, 0);
        check("rst_pwrite", bus.pwrite, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_err", rsp_err, 0);
        @(posedge PCLK);
        #1 PRESETn = 1;

        bus.prdata = 32'hDEADBEEF;
        push(0, 1'b0, 32'h1000, 32'h0);
        run(0, -1, 20, np, nd, pc);
        check("rd_psel_lat", np, 2);
        check("rd_done_lat", nd, 4);
        check("rd_rdata", rsp_rdata, 32'hDEADBEEF);
        check("rd_err", rsp_err, 0);
        idle(ex);
        check("rd_extra_done", ex, 0);

        bus.pready = 0;
        push(1, 1'b1, 32'h2004, 32'h55AA00FF);
        run(1, 7, 20, np, nd, pc);
        check("ws_done_lat", nd, 8);
        check("ws_psel_cycles", pc, 6);
        check("ws_rdata", rsp_rdata, 0);
        check("ws_err", rsp_err, 0);
        idle(ex);
        check("ws_extra_done", ex, 0);

        bus.pready = 0;
        bus.prdata = 32'h12345678;
        push(0, 1'b0, 32'h3000, 32'h0);
        run(0, -1, 30, np, nd, pc);
        check("to_done_lat", nd, 11);
        check("to_err", rsp_err, 1);
        check("to_rdata", rsp_rdata, 0);
        check("to_psel_idle", bus.psel, 0);
        idle(ex);
        check("to_extra_done", ex, 0);

        bus.pready = 0;
        bus.prdata = 32'hCAFEF00D;
        push(1, 1'b0, 32'h3004, 32'h0);
        run(1, 10, 30, np, nd, pc);
        check("tie_done_lat", nd, 11);
        check("tie_err", rsp_err, 0);
        check("tie_rdata", rsp_rdata, 32'hCAFEF00D);
        idle(ex);

        @(negedge PCLK);
        PRESETn = 0;
        bus.pready = 1;
        bus.prdata = 32'h00000077;
        push(0, 1'b0, 32'h10, 32'h0);
        push(0, 1'b1, 32'h14, 32'hA0);
        push(1, 1'b1, 32'h20, 32'hB0);
        push(1, 1'b0, 32'h24, 32'h0);
        @(posedge PCLK);
        #1 PRESETn = 1;
        collect(4, 30, ord, at, drops);
        check("rr_count", ord.size(), 4);
        if (ord.size() == 4) begin
            for (int k = 0; k < 4; k++) check($sformatf("rr_grant%0d", k), ord[k], exp_ord[k]);
            check("rr_first_done", at[0], 4);
            for (int k = 1; k < 4; k++) check($sformatf("rr_gap%0d", k), at[k] - at[k-1], 2);
        end
        check("rr_psel_drops", drops, 0);
        idle(ex);

        bus.pready = 0;
        push(1, 1'b1, 32'h4000, 32'h1111);
        w = 0;
        while (!bus.penable && w < 10) begin
            @(negedge PCLK);
            w++;
        end
        check("ar_in_access", bus.penable, 1);
        #1 q[0].push_back(txn_t'{1'b0, 32'h5000, 32'h0});
        @(posedge PCLK);
        #2 PRESETn = 0;
        #1;
        check("ar_psel", bus.psel, 0);
        check("ar_penable", bus.penable, 0);
        check("ar_done", req_done, 0);
        check("ar_busy", busy, 0);
        @(negedge PCLK);
        @(posedge PCLK);
        #1 PRESETn = 1;
        bus.pready = 1;
        ord.delete();
        at.delete();
        collect(2, 20, ord, at, drops);
        check("ar_count", ord.size(), 2);
        if (ord.size() == 2) begin
            check("ar_first_grant", ord[0], 0);
            check("ar_second_grant", ord[1], 1);
            check("ar_first_done", at[0], 4);
        end
        idle(ex);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end
endmodule
